// File: rtl/user_proj_periph_router_pkg.sv
// Shared definitions for the peripheral router: CSR offsets, pin-select
// encodings, bus FSM states and byte-lane helper.
package user_proj_periph_router_pkg;

    localparam logic [7:0] OFF_PINSEL_LO = 8'h00;
    localparam logic [7:0] OFF_PINSEL_HI = 8'h04;
    localparam logic [7:0] OFF_GPIO_OUT  = 8'h08;
    localparam logic [7:0] OFF_GPIO_IN   = 8'h0C;
    localparam logic [7:0] OFF_IRQ_PEND  = 8'h10;
    localparam logic [7:0] OFF_IRQ_MASK  = 8'h14;
    localparam logic [7:0] OFF_STATUS    = 8'h18;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        PIN_PERI   = 2'd0,
        PIN_GPIO   = 2'd1,
        PIN_INPUT  = 2'd2,
        PIN_DRIVE0 = 2'd3
    } pinsel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCAL = 2'd1,
        ST_FWD   = 2'd2,
        ST_RESP  = 2'd3
    } fwd_state_e;

    // True when the byte lane holding bit idx of a 32-bit word is selected.
    function automatic logic lane_hit(input logic [3:0] sel, input int idx);
        return sel[2'((idx % 32) / 8)];
    endfunction

endpackage

// File: rtl/user_proj_wb_fwd.sv
// Wishbone slave front end: local/remote decode, forwarding FSM with
// timeout, and the registered ack/data returned to the host.
module user_proj_wb_fwd
    import user_proj_periph_router_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_cyc,
    input  logic        wbs_stb,
    input  logic        wbs_we,
    input  logic [31:0] wbs_adr,
    input  logic        peri_ack,
    input  logic [31:0] peri_dat,
    input  logic [31:0] local_rdata,
    output logic        local_req,
    output logic [7:0]  local_off,
    output logic        peri_active,
    output logic        timeout,
    output logic        ack,
    output logic [31:0] dat
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    fwd_state_e  state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        ack_r, ack_s;
    logic [31:0] dat_r, dat_s;
    logic [31:0] off_s;
    logic        is_local_s;
    logic        local_req_s;
    logic        timeout_s;

    // Unsigned offset from the base wraps for addresses below it, so one compare covers both ends.
    assign off_s      = wbs_adr - BASE_ADDR;
    assign is_local_s = (off_s < 32'h0000_0100);

    assign local_off   = off_s[7:0];
    assign local_req   = local_req_s;
    assign timeout     = timeout_s;
    assign peri_active = (state_r == ST_FWD);
    assign ack         = ack_r;
    assign dat         = dat_r;

    // Next-state, timeout counter and response data selection.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        ack_s       = 1'b0;
        dat_s       = 32'h0000_0000;
        local_req_s = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wbs_cyc && wbs_stb && is_local_s) begin
                    state_s     = ST_LOCAL;
                    local_req_s = 1'b1;
                    ack_s       = 1'b1;
                    dat_s       = wbs_we ? 32'h0000_0000 : local_rdata;
                end else if (wbs_cyc && wbs_stb) begin
                    state_s = ST_FWD;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOCAL: state_s = ST_IDLE;
            ST_FWD: begin
                if (!wbs_cyc) begin
                    state_s = ST_IDLE;
                    cnt_s   = 8'd0;
                end else if (peri_ack) begin
                    state_s = ST_RESP;
                    ack_s   = 1'b1;
                    dat_s   = peri_dat;
                    cnt_s   = 8'd0;
                end else if ((cnt_r + 8'd1) == TO_LIMIT) begin
                    state_s   = ST_RESP;
                    ack_s     = 1'b1;
                    dat_s     = TIMEOUT_DATA;
                    timeout_s = 1'b1;
                    cnt_s     = 8'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            ack_r   <= 1'b0;
            dat_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ack_r   <= ack_s;
            dat_r   <= dat_s;
        end
    end

endmodule

// File: rtl/user_proj_periph_router.sv
// Caravel-style user-project router: CSR block, per-pin IO mux, GPIO,
// interrupt aggregation, and forwarding of non-local Wishbone accesses.
module user_proj_periph_router
    import user_proj_periph_router_pkg::*;
#(
    parameter int          NUM_IO      = 12,
    parameter int          NUM_IRQ_SRC = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          TIMEOUT     = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   peri_cyc_o,
    output logic                   peri_stb_o,
    output logic                   peri_we_o,
    output logic [3:0]             peri_sel_o,
    output logic [31:0]            peri_adr_o,
    output logic [31:0]            peri_dat_o,
    input  logic [31:0]            peri_dat_i,
    input  logic                   peri_ack_i,
    input  logic [NUM_IRQ_SRC-1:0] peri_irq_i,
    input  logic [NUM_IO-1:0]      peri_out_i,
    input  logic [NUM_IO-1:0]      peri_oeb_i,
    output logic [NUM_IO-1:0]      peri_in_o,
    input  logic [NUM_IO-1:0]      io_in,
    output logic [NUM_IO-1:0]      io_out,
    output logic [NUM_IO-1:0]      io_oeb,
    output logic [2:0]             irq
);

    logic [2*NUM_IO-1:0]      pinsel_r, pinsel_nxt_s;
    logic [NUM_IO-1:0]        gpio_out_r, gpio_out_nxt_s;
    logic [NUM_IO-1:0]        sync1_r, sync2_r;
    logic [NUM_IRQ_SRC-1:0]   irq_pend_r, irq_mask_r, irq_mask_nxt_s, irq_prev_r, irq_clr_s;
    logic                     toerr_r, toerr_clr_s;
    logic [2:0]               irq_r;
    logic [63:0]              pinsel_img_s;
    logic [31:0]              gpio_out_img_s, gpio_in_img_s, pend_img_s, mask_img_s;
    logic [31:0]              local_rdata_s;
    logic [7:0]               local_off_s;
    logic                     local_req_s, wr_s, timeout_s, peri_active_s;
    logic [NUM_IO-1:0]        io_out_s, io_oeb_s;

    user_proj_wb_fwd #(
        .BASE_ADDR (BASE_ADDR),
        .TIMEOUT   (TIMEOUT)
    ) u_fwd (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_n_i),
        .wbs_cyc     (wbs_cyc_i),
        .wbs_stb     (wbs_stb_i),
        .wbs_we      (wbs_we_i),
        .wbs_adr     (wbs_adr_i),
        .peri_ack    (peri_ack_i),
        .peri_dat    (peri_dat_i),
        .local_rdata (local_rdata_s),
        .local_req   (local_req_s),
        .local_off   (local_off_s),
        .peri_active (peri_active_s),
        .timeout     (timeout_s),
        .ack         (wbs_ack_o),
        .dat         (wbs_dat_o)
    );

    assign wr_s       = local_req_s && wbs_we_i;
    assign peri_cyc_o = peri_active_s;
    assign peri_stb_o = peri_active_s;
    assign peri_we_o  = wbs_we_i;
    assign peri_sel_o = wbs_sel_i;
    assign peri_adr_o = wbs_adr_i;
    assign peri_dat_o = wbs_dat_i;
    assign peri_in_o  = io_in;
    assign io_out     = io_out_s;
    assign io_oeb     = io_oeb_s;
    assign irq        = irq_r;

    // Zero-extended register images; bits beyond NUM_IO/NUM_IRQ_SRC read 0.
    always_comb begin
        pinsel_img_s                   = 64'h0;
        pinsel_img_s[2*NUM_IO-1:0]     = pinsel_r;
        gpio_out_img_s                 = 32'h0;
        gpio_out_img_s[NUM_IO-1:0]     = gpio_out_r;
        gpio_in_img_s                  = 32'h0;
        gpio_in_img_s[NUM_IO-1:0]      = sync2_r;
        pend_img_s                     = 32'h0;
        pend_img_s[NUM_IRQ_SRC-1:0]    = irq_pend_r;
        mask_img_s                     = 32'h0;
        mask_img_s[NUM_IRQ_SRC-1:0]    = irq_mask_r;
    end

    // Local read mux; unmapped offsets return zero.
    always_comb begin
        local_rdata_s = 32'h0;
        case (local_off_s)
            OFF_PINSEL_LO: local_rdata_s = pinsel_img_s[31:0];
            OFF_PINSEL_HI: local_rdata_s = pinsel_img_s[63:32];
            OFF_GPIO_OUT:  local_rdata_s = gpio_out_img_s;
            OFF_GPIO_IN:   local_rdata_s = gpio_in_img_s;
            OFF_IRQ_PEND:  local_rdata_s = pend_img_s;
            OFF_IRQ_MASK:  local_rdata_s = mask_img_s;
            OFF_STATUS:    local_rdata_s = {8'h00, 8'(NUM_IRQ_SRC), 8'(NUM_IO), 7'h00, toerr_r};
            default:       local_rdata_s = 32'h0;
        endcase
    end

    // Byte-lane merge of local writes into the writable CSRs.
    always_comb begin
        pinsel_nxt_s   = pinsel_r;
        gpio_out_nxt_s = gpio_out_r;
        irq_mask_nxt_s = irq_mask_r;
        irq_clr_s      = {NUM_IRQ_SRC{1'b0}};
        toerr_clr_s    = 1'b0;
        for (int i = 0; i < 2*NUM_IO; i++) begin
            if (wr_s && lane_hit(wbs_sel_i, i) &&
                (((i < 32) && (local_off_s == OFF_PINSEL_LO)) ||
                 ((i >= 32) && (local_off_s == OFF_PINSEL_HI)))) begin
                pinsel_nxt_s[i] = wbs_dat_i[5'(i % 32)];
            end else begin
                pinsel_nxt_s[i] = pinsel_r[i];
            end
        end
        for (int i = 0; i < NUM_IO; i++) begin
            if (wr_s && lane_hit(wbs_sel_i, i) && (local_off_s == OFF_GPIO_OUT)) begin
                gpio_out_nxt_s[i] = wbs_dat_i[i];
            end else begin
                gpio_out_nxt_s[i] = gpio_out_r[i];
            end
        end
        for (int i = 0; i < NUM_IRQ_SRC; i++) begin
            if (wr_s && lane_hit(wbs_sel_i, i) && (local_off_s == OFF_IRQ_MASK)) begin
                irq_mask_nxt_s[i] = wbs_dat_i[i];
            end else begin
                irq_mask_nxt_s[i] = irq_mask_r[i];
            end
            if (wr_s && lane_hit(wbs_sel_i, i) && (local_off_s == OFF_IRQ_PEND)) begin
                irq_clr_s[i] = wbs_dat_i[i];
            end else begin
                irq_clr_s[i] = 1'b0;
            end
        end
        if (wr_s && wbs_sel_i[0] && (local_off_s == OFF_STATUS)) begin
            toerr_clr_s = wbs_dat_i[0];
        end else begin
            toerr_clr_s = 1'b0;
        end
    end

    // CSR, synchronizer and interrupt registers; new events win over W1C.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            pinsel_r   <= {NUM_IO{2'b10}};
            gpio_out_r <= {NUM_IO{1'b0}};
            sync1_r    <= {NUM_IO{1'b0}};
            sync2_r    <= {NUM_IO{1'b0}};
            irq_pend_r <= {NUM_IRQ_SRC{1'b0}};
            irq_mask_r <= {NUM_IRQ_SRC{1'b0}};
            irq_prev_r <= {NUM_IRQ_SRC{1'b0}};
            toerr_r    <= 1'b0;
            irq_r      <= 3'b000;
        end else begin
            pinsel_r   <= pinsel_nxt_s;
            gpio_out_r <= gpio_out_nxt_s;
            sync1_r    <= io_in;
            sync2_r    <= sync1_r;
            irq_prev_r <= peri_irq_i;
            irq_pend_r <= (irq_pend_r & ~irq_clr_s) | (peri_irq_i & ~irq_prev_r);
            irq_mask_r <= irq_mask_nxt_s;
            toerr_r    <= (toerr_r & ~toerr_clr_s) | timeout_s;
            irq_r      <= {1'b0, toerr_r, |(irq_pend_r & irq_mask_r)};
        end
    end

    // Per-pin output mux driven by the 2-bit pin-select field.
    always_comb begin
        io_out_s = {NUM_IO{1'b0}};
        io_oeb_s = {NUM_IO{1'b1}};
        for (int p = 0; p < NUM_IO; p++) begin
            case (pinsel_e'(pinsel_r[2*p +: 2]))
                PIN_PERI: begin
                    io_out_s[p] = peri_out_i[p];
                    io_oeb_s[p] = peri_oeb_i[p];
                end
                PIN_GPIO: begin
                    io_out_s[p] = gpio_out_r[p];
                    io_oeb_s[p] = 1'b0;
                end
                PIN_INPUT: begin
                    io_out_s[p] = 1'b0;
                    io_oeb_s[p] = 1'b1;
                end
                PIN_DRIVE0: begin
                    io_out_s[p] = 1'b0;
                    io_oeb_s[p] = 1'b0;
                end
                default: begin
                    io_out_s[p] = 1'b0;
                    io_oeb_s[p] = 1'b1;
                end
            endcase
        end
    end

endmodule
